// File: rtl/irq_controller_if.sv
// CPU-side interrupt handshake: the controller presents irq/cause_id, the CPU answers with ack/eoi.
// ack and eoi are single-cycle pulses sampled on the rising clock edge. ack counts only while irq=1,
// and eoi counts only after an ack has been taken.
interface irq_controller_if #(
  parameter int IDW = 2
);
  logic           irq;
  logic [IDW-1:0] cause_id;
  logic           ack;
  logic           eoi;

  modport master (output irq, output cause_id, input ack, input eoi);
  modport slave  (input irq, input cause_id, output ack, output eoi);
endinterface

// File: rtl/irq_controller.sv
// Synchronises and edge-detects N request lines into a pending register, then presents one
// masked, lowest-index-first interrupt at a time and tracks it through ack/eoi.
module irq_controller #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] src,
  input  logic         mask_we,
  input  logic [N-1:0] mask_wd,
  input  logic         lost_clr,
  irq_controller_if.master cpu,
  output logic [N-1:0] pending,
  output logic [N-1:0] mask,
  output logic [N-1:0] lost,
  output logic         busy,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

  state_t         state, state_next;
  logic [N-1:0]   s1, s2, s3;
  logic [N-1:0]   rise, eligible, clr_vec, lost_set;
  logic [IDW-1:0] winner, cause_r;
  logic           start, take, irq_r, busy_r;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= src;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise     = s2 & ~s3;
  assign eligible = pending & ~mask;

  // Scan downward so the lowest eligible index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) winner = IDW'(i);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_next = REQ;
          start      = 1'b1;
        end
      end
      REQ: begin
        if (cpu.ack) begin
          state_next = SERVICE;
          take       = 1'b1;
        end
      end
      SERVICE: begin
        if (cpu.eoi) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A fresh edge on the source being acknowledged re-arms it rather than counting as lost.
  assign clr_vec  = take ? (N'(1) << cause_r) : '0;
  assign lost_set = rise & pending & ~clr_vec;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      mask    <= '1;
      lost    <= '0;
      cause_r <= '0;
      irq_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      pending <= (pending & ~clr_vec) | rise;
      if (mask_we) mask <= mask_wd;
      lost    <= (lost & ~{N{lost_clr}}) | lost_set;
      if (start) cause_r <= winner;
      irq_r   <= (state_next == REQ);
      busy_r  <= (state_next != IDLE);
    end
  end

  assign cpu.irq      = irq_r;
  assign cpu.cause_id = cause_r;
  assign busy         = busy_r;
  assign state_dbg    = state;

endmodule
